// File: rtl/task_write_pattern.sv
// Writes BYTES_TO_WRITE pattern bytes (SEED+i) to raw SD block FIRST_RAW_BLOCK via multi-block SPI writes.
// Outputs are registered Moore decodes of the next state; every wait on spi_busy is bounded by TIMEOUT_CYCLES.
module task_write_pattern #(
   parameter int unsigned BYTES_TO_WRITE  = 256,
   parameter logic [31:0] FIRST_RAW_BLOCK = 32'd50,
   parameter logic [7:0]  SEED            = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES  = 2**20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        spi_busy,
   input  logic        spi_err,
   output logic        rst_spi,
   output logic        w_multi_block,
   output logic        w_byte,
   output logic [31:0] w_block_addr,
   output logic [7:0]  w_data,
   output logic [31:0] bytes_sent,
   output logic        end_signal,
   output logic        error,
   output logic [31:0] debug
);

   localparam int CNT_W = $clog2(BYTES_TO_WRITE + 1);
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_TO_WRITE);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RST_SPI    = 4'd1,
      WAIT_READY = 4'd2,
      OPEN       = 4'd3,
      BLANK_O    = 4'd4,
      WAIT_OPEN  = 4'd5,
      SEND       = 4'd6,
      BLANK_B    = 4'd7,
      WAIT_BYTE  = 4'd8,
      CLOSE      = 4'd9,
      BLANK_C    = 4'd10,
      WAIT_CLOSE = 4'd11,
      END_STATE  = 4'd12,
      ERROR      = 4'd13
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             rst_spi_q, rst_spi_d;
   logic             w_multi_block_q, w_multi_block_d;
   logic             w_byte_q, w_byte_d;
   logic [7:0]       w_data_q, w_data_d;
   logic             end_signal_q, end_signal_d;
   logic             error_q, error_d;
   logic             in_wait;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = '0;
      in_wait = (state_q == WAIT_READY) || (state_q == WAIT_OPEN) ||
                (state_q == WAIT_BYTE)  || (state_q == WAIT_CLOSE);

      case (state_q)
         IDLE:       if (start) state_d = RST_SPI;
         RST_SPI: begin
            cnt_d   = '0;
            state_d = WAIT_READY;
         end
         WAIT_READY: if (!spi_busy) state_d = OPEN;
         OPEN:       state_d = BLANK_O;
         BLANK_O:    state_d = WAIT_OPEN;
         WAIT_OPEN:  if (!spi_busy) state_d = SEND;
         SEND:       state_d = BLANK_B;
         BLANK_B:    state_d = WAIT_BYTE;
         WAIT_BYTE: begin
            if (!spi_busy) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (cnt_d == CNT_LAST) ? CLOSE : SEND;
            end
         end
         CLOSE:      state_d = BLANK_C;
         BLANK_C:    state_d = WAIT_CLOSE;
         WAIT_CLOSE: if (!spi_busy) state_d = END_STATE;
         END_STATE:  state_d = END_STATE;
         ERROR:      state_d = ERROR;
         default:    state_d = ERROR;
      endcase

      // tmo_d defaults to zero, so it is cleared on entry to every wait state
      if (in_wait && spi_busy) begin
         if (tmo_q == TMO_LAST) state_d = ERROR;
         else                   tmo_d   = tmo_q + TMO_W'(1);
      end

      if (spi_err && (state_q != IDLE) && (state_q != END_STATE) && (state_q != ERROR))
         state_d = ERROR;

      // Outputs decoded from the next state so the registered copies line up with state_q
      rst_spi_d       = (state_d == RST_SPI);
      w_multi_block_d = (state_d == OPEN) || (state_d == BLANK_O) || (state_d == WAIT_OPEN) ||
                        (state_d == SEND) || (state_d == BLANK_B) || (state_d == WAIT_BYTE);
      w_byte_d        = (state_d == SEND);
      end_signal_d    = (state_d == END_STATE);
      error_d         = (state_d == ERROR);
      w_data_d        = SEED + 8'(cnt_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         tmo_q           <= '0;
         rst_spi_q       <= 1'b0;
         w_multi_block_q <= 1'b0;
         w_byte_q        <= 1'b0;
         w_data_q        <= SEED;
         end_signal_q    <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         tmo_q           <= tmo_d;
         rst_spi_q       <= rst_spi_d;
         w_multi_block_q <= w_multi_block_d;
         w_byte_q        <= w_byte_d;
         w_data_q        <= w_data_d;
         end_signal_q    <= end_signal_d;
         error_q         <= error_d;
      end
   end

   assign rst_spi       = rst_spi_q;
   assign w_multi_block = w_multi_block_q;
   assign w_byte        = w_byte_q;
   assign w_block_addr  = FIRST_RAW_BLOCK;
   assign w_data        = w_data_q;
   assign bytes_sent    = 32'(cnt_q);
   assign end_signal    = end_signal_q;
   assign error         = error_q;
   assign debug         = {state_q, 4'h0, w_data_q, 16'(cnt_q)};

endmodule

// File: tb/tb_task_write_pattern.sv
// Directed bench: two instances (SEED A5 / timeout 64, SEED FE / timeout 16) behind a simple SPI busy responder.
module tb_task_write_pattern;

   logic clk, rst;

   logic        start_a, busy_a, err_a;
   logic        rst_spi_a, mb_a, w_byte_a, end_a, error_a;
   logic [31:0] addr_a, bytes_a, debug_a;
   logic [7:0]  data_a;

   logic        start_b, busy_b, err_b;
   logic        rst_spi_b, mb_b, w_byte_b, end_b, error_b;
   logic [31:0] addr_b, bytes_b, debug_b;
   logic [7:0]  data_b;

   int vectors = 0;
   int miscompares = 0;

   task_write_pattern #(.BYTES_TO_WRITE(4), .FIRST_RAW_BLOCK(32'd50), .SEED(8'hA5), .TIMEOUT_CYCLES(64)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .spi_busy(busy_a), .spi_err(err_a),
      .rst_spi(rst_spi_a), .w_multi_block(mb_a), .w_byte(w_byte_a), .w_block_addr(addr_a),
      .w_data(data_a), .bytes_sent(bytes_a), .end_signal(end_a), .error(error_a), .debug(debug_a));

   task_write_pattern #(.BYTES_TO_WRITE(4), .FIRST_RAW_BLOCK(32'd50), .SEED(8'hFE), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .spi_busy(busy_b), .spi_err(err_b),
      .rst_spi(rst_spi_b), .w_multi_block(mb_b), .w_byte(w_byte_b), .w_block_addr(addr_b),
      .w_data(data_b), .bytes_sent(bytes_b), .end_signal(end_b), .error(error_b), .debug(debug_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI responder: busy 3 cycles per byte, 2 around open/close, rdy_dly after a controller reset
   int         bc_a = 0, rdy_dly_a = 2, pulses_a = 0, rstspi_a = 0;
   logic       mb_prev_a = 1'b0;
   logic [7:0] seen_a[$];
   always @(negedge clk) begin
      if (bc_a > 0) bc_a--;
      if (w_byte_a) begin bc_a = 3; pulses_a++; seen_a.push_back(data_a); end
      if (rst_spi_a) begin bc_a = rdy_dly_a; rstspi_a++; end
      if (mb_a != mb_prev_a && !error_a) bc_a = 2;
      mb_prev_a = mb_a;
      busy_a = (bc_a > 0);
   end

   int         bc_b = 0, pulses_b = 0, rstspi_b = 0;
   logic       mb_prev_b = 1'b0, stuck_b = 1'b0, arm_stuck_b = 1'b0;
   logic [7:0] seen_b[$];
   always @(negedge clk) begin
      if (bc_b > 0) bc_b--;
      if (w_byte_b) begin bc_b = 3; pulses_b++; seen_b.push_back(data_b); end
      if (rst_spi_b) begin bc_b = 2; rstspi_b++; end
      if (mb_b != mb_prev_b && !error_b) bc_b = 2;
      mb_prev_b = mb_b;
      if (!rst) stuck_b = 1'b0;
      else if (arm_stuck_b && mb_b) stuck_b = 1'b1;
      busy_b = stuck_b || (bc_b > 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_state_a(input logic [3:0] st, input int budget, input string tag);
      int n = 0;
      while (debug_a[31:28] != st && n < budget) begin @(negedge clk); n++; end
      chk(tag, 32'(debug_a[31:28] == st), 32'd1);
   endtask

   task automatic wait_state_b(input logic [3:0] st, input int budget, input string tag);
      int n = 0;
      while (debug_b[31:28] != st && n < budget) begin @(negedge clk); n++; end
      chk(tag, 32'(debug_b[31:28] == st), 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
   endtask

   logic [7:0] exp_a[4] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};
   logic [7:0] exp_b[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
   int base_p, base_r, n;

   initial begin
      rst = 1'b0;
      start_a = 1'b0; err_a = 1'b0;
      start_b = 1'b0; err_b = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_spi_a", 32'(rst_spi_a), 32'd0);
      chk("mb_a", 32'(mb_a), 32'd0);
      chk("w_byte_a", 32'(w_byte_a), 32'd0);
      chk("w_data_a", 32'(data_a), 32'hA5);
      chk("bytes_a", bytes_a, 32'd0);
      chk("end_a", 32'(end_a), 32'd0);
      chk("error_a", 32'(error_a), 32'd0);
      chk("debug_a", debug_a, 32'h00A5_0000);
      chk("addr_a", addr_a, 32'd50);
      chk("w_data_b", 32'(data_b), 32'hFE);
      chk("debug_b", debug_b, 32'h00FE_0000);
      chk("addr_b", addr_b, 32'd50);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);

      // Normal session, SEED A5
      base_p = pulses_a; base_r = rstspi_a;
      start_a = 1'b1; @(negedge clk) start_a = 1'b0;
      wait_state_a(4'd12, 500, "done_a1");
      repeat (5) @(negedge clk);
      chk("rstspi_cnt_a1", 32'(rstspi_a - base_r), 32'd1);
      chk("pulses_a1", 32'(pulses_a - base_p), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("byte_a1[%0d]", i), 32'(seen_a[base_p + i]), 32'(exp_a[i]));
      chk("bytes_a1", bytes_a, 32'd4);
      chk("end_a1", 32'(end_a), 32'd1);
      chk("mb_a1", 32'(mb_a), 32'd0);
      chk("error_a1", 32'(error_a), 32'd0);

      // Wrap-around session, SEED FE
      base_p = pulses_b;
      start_b = 1'b1; @(negedge clk) start_b = 1'b0;
      wait_state_b(4'd12, 500, "done_b1");
      repeat (5) @(negedge clk);
      chk("pulses_b1", 32'(pulses_b - base_p), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("byte_b1[%0d]", i), 32'(seen_b[base_p + i]), 32'(exp_b[i]));
      chk("end_b1", 32'(end_b), 32'd1);
      chk("bytes_b1", bytes_b, 32'd4);

      // spi_err while waiting on byte 2
      pulse_reset();
      base_p = pulses_a;
      start_a = 1'b1; @(negedge clk) start_a = 1'b0;
      n = 0;
      while (!(debug_a[31:28] == 4'd8 && bytes_a == 32'd1) && n < 500) begin @(negedge clk); n++; end
      chk("reach_wait_byte2", 32'(n < 500), 32'd1);
      err_a = 1'b1;
      @(negedge clk) err_a = 1'b0;
      chk("error_a_err", 32'(error_a), 32'd1);
      chk("bytes_a_err", bytes_a, 32'd1);
      chk("end_a_err", 32'(end_a), 32'd0);
      repeat (20) @(negedge clk);
      chk("pulses_a_err", 32'(pulses_a - base_p), 32'd2);
      chk("mb_a_err", 32'(mb_a), 32'd0);
      chk("error_a_sticky", 32'(error_a), 32'd1);

      // Timeout: busy stuck after OPEN, TIMEOUT_CYCLES=16
      pulse_reset();
      arm_stuck_b = 1'b1;
      base_p = pulses_b;
      start_b = 1'b1; @(negedge clk) start_b = 1'b0;
      wait_state_b(4'd5, 100, "reach_wait_open_b");
      repeat (15) @(negedge clk);
      chk("error_b_15", 32'(error_b), 32'd0);
      @(negedge clk);
      chk("error_b_16", 32'(error_b), 32'd1);
      chk("mb_b_tmo", 32'(mb_b), 32'd0);
      chk("pulses_b_tmo", 32'(pulses_b - base_p), 32'd0);
      arm_stuck_b = 1'b0;

      // Long busy after the controller reset
      pulse_reset();
      rdy_dly_a = 50;
      base_p = pulses_a;
      start_a = 1'b1; @(negedge clk) start_a = 1'b0;
      wait_state_a(4'd2, 20, "reach_wait_ready_a");
      repeat (40) @(negedge clk);
      chk("still_wait_ready_a", 32'(debug_a[31:28]), 32'd2);
      chk("mb_a_wait_ready", 32'(mb_a), 32'd0);
      wait_state_a(4'd12, 500, "done_a_slow");
      rdy_dly_a = 2;
      repeat (5) @(negedge clk);
      chk("pulses_a_slow", 32'(pulses_a - base_p), 32'd4);
      chk("bytes_a_slow", bytes_a, 32'd4);
      chk("error_a_slow", 32'(error_a), 32'd0);

      // Asynchronous reset mid-session, then a fresh session
      pulse_reset();
      start_a = 1'b1; @(negedge clk) start_a = 1'b0;
      n = 0;
      while (bytes_a != 32'd2 && n < 500) begin @(negedge clk); n++; end
      chk("reach_byte2_a", 32'(n < 500), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_w_byte", 32'(w_byte_a), 32'd0);
      chk("arst_mb", 32'(mb_a), 32'd0);
      chk("arst_bytes", bytes_a, 32'd0);
      chk("arst_debug", debug_a, 32'h00A5_0000);
      chk("arst_rst_spi", 32'(rst_spi_a), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      base_p = pulses_a; base_r = rstspi_a;
      start_a = 1'b1; @(negedge clk) start_a = 1'b0;
      wait_state_a(4'd12, 500, "done_a_rerun");
      repeat (5) @(negedge clk);
      chk("rstspi_cnt_rerun", 32'(rstspi_a - base_r), 32'd1);
      chk("pulses_rerun", 32'(pulses_a - base_p), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("byte_rerun[%0d]", i), 32'(seen_a[base_p + i]), 32'(exp_a[i]));
      chk("bytes_rerun", bytes_a, 32'd4);
      chk("end_rerun", 32'(end_a), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
